scan_mux: RTL and testbench
===========================

# scan_mux

Parametrised, registered N-channel selector for the game datapath: picks one WIDTH-bit channel out of CHANNELS inputs, either by an externally driven select or by an internal auto-scan that rotates through channels at a programmable rate. Drives the digit/LED multiplexing and mole-slot selection paths, replacing the fixed combinational 2:1 select with a clocked, glitch-free output plus one-hot channel enables.

## Interface
- WIDTH, 4, bits per channel
- CHANNELS, 4, number of input channels (≥2)
- DIV, 1000, clocks per channel in auto-scan (≥1)
- SEL_W, derived = clog2(CHANNELS), select width (not overridden)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = manual select, 1 = auto-scan
- sel  input  SEL_W  channel index in manual mode
- hold  input  1  freeze channel pointer (and prescaler in auto)
- din  input  CHANNELS*WIDTH  packed channels; channel k = din[k*WIDTH +: WIDTH]
- q  output  WIDTH  selected channel data, registered
- q_sel  output  SEL_W  index of channel currently on q
- ch_oh  output  CHANNELS  one-hot of q_sel
- tick  output  1  one-cycle pulse when auto-scan advances

## Operation
- Internal state: pointer ptr (SEL_W), prescaler pcnt (0..DIV-1), previous mode bit.
- Each edge computes ptr_next, then registers ptr <= ptr_next, q <= din[ptr_next], q_sel <= ptr_next, ch_oh <= 1<<ptr_next. q, q_sel, ch_oh always mutually consistent.
- Manual (mode=0): ptr_next = sel if sel < CHANNELS, else ptr (out-of-range ignored). pcnt held at 0. tick = 0.
- Auto (mode=1): pcnt increments; at pcnt = DIV-1, pcnt <= 0, ptr_next = ptr+1, wrapping CHANNELS-1 -> 0, tick <= 1 that same edge; otherwise ptr_next = ptr, tick <= 0.
- DIV=1: advance every cycle, tick constantly high.
- hold=1: ptr_next = ptr in both modes, pcnt frozen, tick = 0; q still re-samples din[ptr] every cycle.
- Mode manual->auto: pcnt cleared to 0 on the first auto cycle; scan starts from current ptr; first advance DIV cycles later.
- Mode auto->manual: sel takes effect at the same edge mode is first seen 0; pending scan count discarded.
- hold and terminal count in the same cycle: hold wins, no advance, pcnt stays at DIV-1, advance occurs first cycle after hold drops.

## Timing
- Reset (rst=1 at edge): ptr=0, pcnt=0, q=0, q_sel=0, ch_oh=0 (all enables off), tick=0. rst overrides mode, hold, sel.
- First edge after rst deasserts loads channel per rules above (ch_oh becomes non-zero).
- Latency: sel or din change -> q one clock.
- Auto-scan period: exactly DIV clocks per channel, CHANNELS*DIV per full rotation (hold excluded).
- tick coincides with the cycle q_sel first shows the new channel.
- Reset mid-scan: prescaler phase lost; scan restarts from channel 0 with full DIV interval.
- No combinational path input->output.

## Structure
- Shared package: MODE_MANUAL=0, MODE_AUTO=1 constants; clog2 function used for SEL_W and prescaler width.
- Sub-module scan_prescaler: counter 0..DIV-1 with enable (auto & !hold), synchronous clear (rst or mode entry), terminal-count pulse output. Selection, pointer and output registers stay in scan_mux.

## Test plan
- Reset: assert rst 3 cycles with mode=1, hold=0 -> q=0, q_sel=0, ch_oh=4'b0000, tick=0; first edge after release ch_oh=4'b0001.
- Manual: WIDTH=4, din={4'hD,4'hC,4'hB,4'hA}, sel 0->2->3 -> q A, C, D one cycle after each sel change, ch_oh 0001, 0100, 1000.
- Out-of-range: CHANNELS=3, sel=3 after sel=1 -> q_sel stays 1, q stays channel 1.
- Auto wrap: DIV=4, CHANNELS=4 -> q_sel 0,1,2,3,0 at 4-clock intervals, tick high exactly on each change, 4 pulses per 16 clocks.
- Hold: in auto, hold=1 for 10 cycles when pcnt=DIV-1 -> no tick, q_sel constant, din change still on q after 1 clock; advance on first cycle after hold drops.
- Mode switch/reset mid-scan: auto at q_sel=2, switch to manual with sel=0 -> q_sel=0 next edge; back to auto -> first advance after exactly DIV clocks; rst mid-interval -> q_sel=0, next advance DIV clocks after release.

Source files
------------

// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux channel selector: mode encoding and
// width helpers used to size the select pointer and the scan prescaler.
package scan_mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  function automatic int clog2(input int n);
    int r = 0;
    int v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A counter that only ever holds 0 still needs one bit of storage.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/scan_mux_if.sv
// Channel selector bus: control and packed channel data in, selected
// channel, its index, one-hot enables and scan tick out.
interface scan_mux_if
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);

  localparam int SEL_W = clog2(CHANNELS);

  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic                      hold;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0]          q;
  logic [SEL_W-1:0]          q_sel;
  logic [CHANNELS-1:0]       ch_oh;
  logic                      tick;

  modport master (
    output mode, sel, hold, din,
    input  q, q_sel, ch_oh, tick
  );

  modport slave (
    input  mode, sel, hold, din,
    output q, q_sel, ch_oh, tick
  );

endinterface

// File: rtl/scan_mux_prescaler.sv
// Auto-scan prescaler: counts 0..DIV-1 while enabled and flags the
// terminal count combinationally so the pointer advances on that same edge.
module scan_prescaler
  import scan_mux_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int            CW   = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel selector with manual select or timed auto-scan;
// q, q_sel and ch_oh are all loaded from the same next-pointer value.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DIV      = 1000
) (
  input logic       clk,
  input logic       rst,
  scan_mux_if.slave bus
);

  localparam int SEL_W = clog2(CHANNELS);

  logic             w_auto;
  logic             w_tc;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_ptr_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_auto = (bus.mode == MODE_AUTO);

  // Clearing for the whole manual period also covers the manual->auto entry.
  scan_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .i_clr (rst || !w_auto),
    .i_en  (w_auto && !bus.hold),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_ptr_next = r_ptr;
    if (!bus.hold) begin
      if (!w_auto) begin
        if (int'(bus.sel) < CHANNELS) begin
          w_ptr_next = bus.sel;
        end
      end else if (w_tc) begin
        w_ptr_next = (r_ptr == SEL_W'(CHANNELS - 1)) ? '0 : r_ptr + SEL_W'(1);
      end
    end
  end

  always_comb begin
    w_q_next = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (w_ptr_next == SEL_W'(k)) begin
        w_q_next = bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      bus.q     <= '0;
      bus.q_sel <= '0;
      bus.ch_oh <= '0;
      bus.tick  <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_next;
      bus.q     <= w_q_next;
      bus.q_sel <= w_ptr_next;
      bus.ch_oh <= CHANNELS'(1) << w_ptr_next;
      bus.tick  <= w_tc;
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: three parameterisations share one stimulus
// stream; a behavioural model queues expected outputs for a separate monitor.
module tb_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  sel = '0;
  logic [15:0] din = '0;

  always #5 clk = ~clk;

  scan_mux_if #(.WIDTH(4), .CHANNELS(4)) if0 ();
  scan_mux_if #(.WIDTH(4), .CHANNELS(3)) if1 ();
  scan_mux_if #(.WIDTH(4), .CHANNELS(2)) if2 ();

  assign if0.mode = mode;
  assign if0.hold = hold;
  assign if0.sel  = sel;
  assign if0.din  = din;
  assign if1.mode = mode;
  assign if1.hold = hold;
  assign if1.sel  = sel;
  assign if1.din  = din[11:0];
  assign if2.mode = mode;
  assign if2.hold = hold;
  assign if2.sel  = sel[0];
  assign if2.din  = din[7:0];

  scan_mux #(.WIDTH(4), .CHANNELS(4), .DIV(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  scan_mux #(.WIDTH(4), .CHANNELS(3), .DIV(5)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  scan_mux #(.WIDTH(4), .CHANNELS(2), .DIV(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct packed {
    logic [3:0] q;
    logic [1:0] qs;
    logic [3:0] oh;
    logic       tk;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  int checks = 0;
  int errors = 0;

  int CH[3] = '{4, 3, 2};
  int DV[3] = '{4, 5, 1};
  int m_ptr[3];
  int m_pcnt[3];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue what each DUT must show after the edge.
  task automatic step(input logic r, input logic m, input logic h,
                      input logic [1:0] s, input logic [15:0] d);
    exp_t e;
    int   sv;
    @(negedge clk);
    rst = r; mode = m; hold = h; sel = s; din = d;
    for (int k = 0; k < 3; k++) begin
      sv   = (k == 2) ? int'(s[0]) : int'(s);
      e.tk = 1'b0;
      if (r) begin
        m_ptr[k]  = 0;
        m_pcnt[k] = 0;
      end else if (!m) begin
        m_pcnt[k] = 0;
        if (!h && sv < CH[k]) m_ptr[k] = sv;
      end else if (!h) begin
        if (m_pcnt[k] == DV[k] - 1) begin
          m_pcnt[k] = 0;
          m_ptr[k]  = (m_ptr[k] + 1) % CH[k];
          e.tk      = 1'b1;
        end else begin
          m_pcnt[k]++;
        end
      end
      if (r) begin
        e.q  = '0;
        e.qs = '0;
        e.oh = '0;
      end else begin
        e.q  = 4'((d >> (4 * m_ptr[k])) & 16'hF);
        e.qs = 2'(m_ptr[k]);
        e.oh = 4'(1 << m_ptr[k]);
      end
      case (k)
        0:       sb0.push_back(e);
        1:       sb1.push_back(e);
        default: sb2.push_back(e);
      endcase
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [3:0] q,
                     input logic [1:0] qs, input logic [3:0] oh, input logic tk);
    chk({nm, ".q"},     int'(q),  int'(e.q));
    chk({nm, ".q_sel"}, int'(qs), int'(e.qs));
    chk({nm, ".ch_oh"}, int'(oh), int'(e.oh));
    chk({nm, ".tick"},  int'(tk), int'(e.tk));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        cmp("dut0", e, if0.q, if0.q_sel, if0.ch_oh, if0.tick);
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        cmp("dut1", e, if1.q, if1.q_sel, {1'b0, if1.ch_oh}, if1.tick);
      end
      if (sb2.size() > 0) begin
        e = sb2.pop_front();
        cmp("dut2", e, if2.q, {1'b0, if2.q_sel}, {2'b0, if2.ch_oh}, if2.tick);
      end
    end
  end

  initial begin : driver
    logic [15:0] D;
    logic        rm, rh, rr;
    logic [1:0]  rs;
    D = 16'hDCBA;

    repeat (3) step(1, 1, 0, 0, D);
    step(0, 1, 0, 0, D);
    // Manual select, including out-of-range index on the 3-channel unit.
    repeat (2) step(0, 0, 0, 0, D);
    repeat (2) step(0, 0, 0, 2, D);
    repeat (2) step(0, 0, 0, 3, D);
    repeat (2) step(0, 0, 0, 1, D);
    repeat (2) step(0, 0, 0, 3, D);
    // Auto wrap from channel 0.
    step(0, 0, 0, 0, D);
    repeat (20) step(0, 1, 0, 0, D);
    // Hold entered exactly at terminal count of the DIV=4 unit.
    step(0, 0, 0, 0, D);
    repeat (3) step(0, 1, 0, 0, D);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 16'($urandom));
    repeat (6) step(0, 1, 0, 0, D);
    // Back to manual mid-scan, re-enter auto, then reset mid-interval.
    step(0, 0, 0, 0, D);
    repeat (10) step(0, 1, 0, 0, D);
    step(0, 1, 0, 0, D);
    step(1, 1, 0, 0, D);
    repeat (12) step(0, 1, 0, 0, D);

    rm = 1'b1;
    rs = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) rm = ~rm;
      if ($urandom_range(0, 3) == 0) rs = 2'($urandom);
      rh = ($urandom_range(0, 7) == 0);
      rr = ($urandom_range(0, 199) == 0);
      step(rr, rm, rh, rs, 16'($urandom));
    end

    repeat (2) @(negedge clk);
    chk("drain", sb0.size() + sb1.size() + sb2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
